sad_search_ctrl: RTL and testbench
==================================

# sad_search_ctrl

Search scheduler for the partial-sum SAD engine. It runs the engine once per candidate block over N_CAND candidates, issues the candidate index to the pixel-fetch unit and relays its data-ready handshake to the engine. It tracks the minimum SAD and the index that produced it, and reports both to the host with a done/ack handshake. It sits between the motion-estimation host and the SAD top level.

## Interface
- WIDTH, 8, pixel width; SAD result width is WIDTH+5
- N_CAND, 16, candidates per search, minimum 2
- IDX_W, $clog2(N_CAND), candidate index width
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a search; sampled in IDLE only
- ack  in  1  host acknowledges the result; sampled in FIN only
- done  out  1  result valid; held until ack
- best_sad  out  WIDTH+5  minimum SAD found
- best_idx  out  IDX_W  candidate index of best_sad
- mem_req  out  1  fetch request for candidate mem_idx
- mem_idx  out  IDX_W  current candidate index
- mem_rdy  in  1  fetch unit has pixel lanes valid
- sad_init  out  1  one-cycle start pulse to the engine
- sad_load  in  1  engine requests the next pixel group
- sad_loaded  out  1  pixel group valid, to the engine
- sad_done  in  1  engine result valid
- sad_ack  out  1  one-cycle release pulse to the engine
- sad_value  in  WIDTH+5  engine SAD result

## Operation
- States: IDLE, START, WAIT, CMP, FIN.
- IDLE: on start=1, clear cand to 0, set best_sad to all-ones and best_idx to 0, then go to START.
- START: drive sad_init=1 for one cycle with mem_idx=cand, then go to WAIT.
- WAIT:
  - mem_req = sad_load.
  - sad_loaded = sad_load & mem_rdy.
  - On sad_done=1, register sad_value and go to CMP.
- CMP:
  - Drive sad_ack=1 for one cycle.
  - If sad_value_reg < best_sad (strict), update best_sad and best_idx to cand. On a tie, the earlier index is kept.
  - If cand == N_CAND-1, go to FIN. Otherwise increment cand and go to START.
- FIN: done=1. On ack=1, go to IDLE.
- best_sad and best_idx hold their values until the next start.
- start while not in IDLE is ignored. ack outside FIN is ignored.
- sad_done is sampled only in WAIT, so a level that lingers during CMP or START has no effect.
- The comparison is unsigned at full WIDTH+5 bits. No saturation is needed.

## Timing
- Reset values:
  - State IDLE, cand 0.
  - done, mem_req, sad_init, sad_loaded, sad_ack all 0.
  - best_sad all-ones, best_idx 0, mem_idx 0.
- Reset asserted mid-search aborts the search immediately: all outputs take their reset values asynchronously.
- Per-candidate overhead is 2 cycles beyond the engine latency (START + CMP).
- done rises the cycle after the CMP of the final candidate.
- Host ack is consumed in 1 cycle: with ack held high in FIN, done is 0 on the next cycle and start is accepted that same cycle.
- mem_req and sad_loaded are combinational from state, sad_load and mem_rdy. All other outputs are registered.
- mem_rdy low stalls the engine indefinitely. No timeout.

## Configuration
- SAD_EARLY_EXIT_EN
- Defined: in CMP, a sad_value_reg of 0 updates best and goes straight to FIN, skipping the remaining candidates.
- Undefined: all N_CAND candidates are always visited. A zero SAD is treated like any other value.

## Structure
- Package sad_search_pkg holds:
  - state enum (IDLE, START, WAIT, CMP, FIN)
  - SAD_W = WIDTH+5 helper
  - BEST_INIT all-ones constant
- Sub-module sad_min_tracker holds:
  - best_sad/best_idx registers
  - strict less-than comparator
  - clear input (driven on start) and update-enable input (driven in CMP)

## Test plan
- Basic search: N_CAND=4, SADs 100, 40, 40, 70 → done with best_sad=40, best_idx=1 (tie keeps earlier index); exactly 4 sad_init and 4 sad_ack pulses.
- Early exit: SADs 30, 0, 10, 5 with SAD_EARLY_EXIT_EN defined → best_sad=0, best_idx=1, 2 sad_init pulses. Without the macro → 4 pulses, same result.
- Backpressure: mem_rdy low for 5 cycles while sad_load=1 → sad_loaded stays 0, mem_req stays 1, state stays WAIT, result unchanged.
- Reset mid-search: rst pulse during WAIT of candidate 2 → next cycle all outputs are at reset values; a subsequent start runs a full, correct search.
- Handshake:
  - start pulsed during WAIT → ignored.
  - ack held low for 10 cycles in FIN → done held, best_sad/best_idx stable.
  - ack=1 → done=0 on the next cycle.
- All-max values: all SADs = 2^(WIDTH+5)-1 → best_sad all-ones, best_idx=0.

Source files
------------

// File: rtl/sad_search_pkg.sv
// Shared types and constants for the SAD candidate search scheduler.
package sad_search_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned SAD_W     = DEF_WIDTH + 5;
  localparam logic [SAD_W-1:0] BEST_INIT = {SAD_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    CMP,
    FIN
  } state_e;

  // SAD accumulator width for a given pixel width
  function automatic int unsigned sad_w(input int unsigned width);
    return width + 5;
  endfunction

endpackage

// File: rtl/sad_min_tracker.sv
// Running minimum of SAD results and the candidate index that produced it.
module sad_min_tracker
  import sad_search_pkg::*;
#(
  parameter int unsigned SAD_WP = SAD_W,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_upd,
  input  logic [SAD_WP-1:0] i_value,
  input  logic [IDX_W-1:0]  i_idx,
  output logic [SAD_WP-1:0] o_best_sad,
  output logic [IDX_W-1:0]  o_best_idx
);

  logic [SAD_WP-1:0] r_best_sad;
  logic [IDX_W-1:0]  r_best_idx;
  logic              w_less;

  // Strict compare: on a tie the earlier candidate stays the winner
  assign w_less = (i_value < r_best_sad);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_best_sad <= '1;
      r_best_idx <= '0;
    end else if (i_clr) begin
      r_best_sad <= '1;
      r_best_idx <= '0;
    end else if (i_upd && w_less) begin
      r_best_sad <= i_value;
      r_best_idx <= i_idx;
    end
  end

  assign o_best_sad = r_best_sad;
  assign o_best_idx = r_best_idx;

endmodule

// File: rtl/sad_search_ctrl.sv
// Candidate search scheduler for the SAD engine; tracks the best match.
// Optional SAD_EARLY_EXIT_EN: a zero SAD ends the search immediately.
module sad_search_ctrl
  import sad_search_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned N_CAND = 16,
  parameter int unsigned IDX_W  = $clog2(N_CAND)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 ack,
  output logic                 done,
  output logic [WIDTH+5-1:0]   best_sad,
  output logic [IDX_W-1:0]     best_idx,
  output logic                 mem_req,
  output logic [IDX_W-1:0]     mem_idx,
  input  logic                 mem_rdy,
  output logic                 sad_init,
  input  logic                 sad_load,
  output logic                 sad_loaded,
  input  logic                 sad_done,
  output logic                 sad_ack,
  input  logic [WIDTH+5-1:0]   sad_value
);

  localparam int unsigned L_SAD_W = sad_w(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CAND - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [IDX_W-1:0]   r_cand;
  logic [IDX_W-1:0]   w_cand_nxt;
  logic [L_SAD_W-1:0] r_sad_val;
  logic               r_done;
  logic               r_sad_init;
  logic               r_sad_ack;
  logic               w_clr;
  logic               w_upd;
  logic               w_last;

`ifdef SAD_EARLY_EXIT_EN
  assign w_last = (r_cand == LAST_IDX) || (r_sad_val == '0);
`else
  assign w_last = (r_cand == LAST_IDX);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cand     <= '0;
      r_sad_val  <= '0;
      r_done     <= 1'b0;
      r_sad_init <= 1'b0;
      r_sad_ack  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cand     <= w_cand_nxt;
      r_done     <= (w_state_nxt == FIN);
      r_sad_init <= (w_state_nxt == START);
      r_sad_ack  <= (w_state_nxt == CMP);
      if (r_state == WAIT && sad_done) begin
        r_sad_val <= sad_value;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_clr       = 1'b0;
    w_upd       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_cand_nxt  = '0;
          w_clr       = 1'b1;
          w_state_nxt = START;
        end
      end
      START: w_state_nxt = WAIT;
      WAIT: begin
        if (sad_done) begin
          w_state_nxt = CMP;
        end
      end
      CMP: begin
        w_upd = 1'b1;
        if (w_last) begin
          w_state_nxt = FIN;
        end else begin
          w_cand_nxt  = r_cand + 1'b1;
          w_state_nxt = START;
        end
      end
      FIN: begin
        if (ack) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  sad_min_tracker #(
    .SAD_WP(L_SAD_W),
    .IDX_W (IDX_W)
  ) u_min (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_clr),
    .i_upd     (w_upd),
    .i_value   (r_sad_val),
    .i_idx     (r_cand),
    .o_best_sad(best_sad),
    .o_best_idx(best_idx)
  );

  // Fetch handshake is a straight relay while the engine is running
  assign mem_req    = (r_state == WAIT) && sad_load;
  assign sad_loaded = (r_state == WAIT) && sad_load && mem_rdy;

  assign done     = r_done;
  assign sad_init = r_sad_init;
  assign sad_ack  = r_sad_ack;
  assign mem_idx  = r_cand;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Directed bench for sad_search_ctrl with a small SAD engine model.
module tb_sad_search_ctrl;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned N_CAND = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned SW     = WIDTH + 5;
  localparam logic [SW-1:0] ALL1 = {SW{1'b1}};

  logic             clk;
  logic             rst;
  logic             start;
  logic             ack;
  logic             done;
  logic [SW-1:0]    best_sad;
  logic [IDX_W-1:0] best_idx;
  logic             mem_req;
  logic [IDX_W-1:0] mem_idx;
  logic             mem_rdy;
  logic             sad_init;
  logic             sad_load;
  logic             sad_loaded;
  logic             sad_done;
  logic             sad_ack;
  logic [SW-1:0]    sad_value;

  logic [SW-1:0]    sad_tab [N_CAND];
  int               n_init;
  int               n_ack;
  int               n_chk;
  int               n_fail;

  sad_search_ctrl #(
    .WIDTH (WIDTH),
    .N_CAND(N_CAND),
    .IDX_W (IDX_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ack       (ack),
    .done      (done),
    .best_sad  (best_sad),
    .best_idx  (best_idx),
    .mem_req   (mem_req),
    .mem_idx   (mem_idx),
    .mem_rdy   (mem_rdy),
    .sad_init  (sad_init),
    .sad_load  (sad_load),
    .sad_loaded(sad_loaded),
    .sad_done  (sad_done),
    .sad_ack   (sad_ack),
    .sad_value (sad_value)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Engine model: init -> request one pixel group -> result held until ack
  initial begin
    int phase;
    int cur;
    phase = 0;
    cur = 0;
    n_init = 0;
    n_ack = 0;
    sad_load = 1'b0;
    sad_done = 1'b0;
    sad_value = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase = 0;
        sad_load = 1'b0;
        sad_done = 1'b0;
      end else begin
        if (sad_init) n_init++;
        if (sad_ack) n_ack++;
        case (phase)
          0: if (sad_init) begin
               cur = int'(mem_idx);
               phase = 1;
             end
          1: begin
               sad_load = 1'b1;
               phase = 2;
             end
          2: if (sad_loaded) begin
               sad_load = 1'b0;
               sad_done = 1'b1;
               sad_value = sad_tab[cur];
               phase = 3;
             end
          default: if (sad_ack) begin
               sad_done = 1'b0;
               phase = 0;
             end
        endcase
      end
    end
  end

  task automatic set_tab(input logic [SW-1:0] a, input logic [SW-1:0] b,
                         input logic [SW-1:0] c, input logic [SW-1:0] d);
    sad_tab[0] = a;
    sad_tab[1] = b;
    sad_tab[2] = c;
    sad_tab[3] = d;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 500; i++) begin
      if (done) break;
      @(negedge clk);
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    @(negedge clk);
    chk(tag, 32'(done), 32'd0);
    ack = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_bsad"}, 32'(best_sad), 32'(ALL1));
    chk({tag, "_bidx"}, 32'(best_idx), 32'd0);
    chk({tag, "_midx"}, 32'(mem_idx), 32'd0);
    chk({tag, "_init"}, 32'(sad_init), 32'd0);
    chk({tag, "_sack"}, 32'(sad_ack), 32'd0);
    chk({tag, "_mreq"}, 32'(mem_req), 32'd0);
    chk({tag, "_ldd"}, 32'(sad_loaded), 32'd0);
  endtask

  initial begin
    int i0;
    int a0;
    int exp_n;
    bit hit;
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    start = 1'b0;
    ack = 1'b0;
    mem_rdy = 1'b1;
    set_tab(13'd0, 13'd0, 13'd0, 13'd0);
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    rst = 1'b0;
    @(negedge clk);

    // Basic search with a tie at the minimum
    set_tab(13'd100, 13'd40, 13'd40, 13'd70);
    i0 = n_init;
    a0 = n_ack;
    do_start();
    wait_done("basic_done");
    chk("basic_sad", 32'(best_sad), 32'd40);
    chk("basic_idx", 32'(best_idx), 32'd1);
    chk("basic_inits", 32'(n_init - i0), 32'd4);
    chk("basic_acks", 32'(n_ack - a0), 32'd4);
    repeat (10) @(negedge clk);
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_sad", 32'(best_sad), 32'd40);
    chk("hold_idx", 32'(best_idx), 32'd1);
    do_ack("basic_ack");

    // Zero SAD on candidate 1
    set_tab(13'd30, 13'd0, 13'd10, 13'd5);
`ifdef SAD_EARLY_EXIT_EN
    exp_n = 2;
`else
    exp_n = 4;
`endif
    i0 = n_init;
    a0 = n_ack;
    do_start();
    wait_done("zero_done");
    chk("zero_sad", 32'(best_sad), 32'd0);
    chk("zero_idx", 32'(best_idx), 32'd1);
    chk("zero_inits", 32'(n_init - i0), 32'(exp_n));
    chk("zero_acks", 32'(n_ack - a0), 32'(exp_n));
    do_ack("zero_ack");

    // Fetch backpressure on candidate 0, plus a stray start during WAIT
    set_tab(13'd500, 13'd300, 13'd12, 13'd12);
    mem_rdy = 1'b0;
    i0 = n_init;
    do_start();
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_req) begin
        hit = 1'b1;
        break;
      end
    end
    chk("bp_reach_wait", 32'(hit), 32'd1);
    do_start();
    for (int i = 0; i < 5; i++) begin
      chk("bp_loaded", 32'(sad_loaded), 32'd0);
      chk("bp_mem_req", 32'(mem_req), 32'd1);
      chk("bp_no_init", 32'(sad_init), 32'd0);
      @(negedge clk);
    end
    chk("bp_sad_hold", 32'(best_sad), 32'(ALL1));
    chk("bp_idx_hold", 32'(mem_idx), 32'd0);
    mem_rdy = 1'b1;
    wait_done("bp_done");
    chk("bp_sad", 32'(best_sad), 32'd12);
    chk("bp_idx", 32'(best_idx), 32'd2);
    chk("bp_inits", 32'(n_init - i0), 32'd4);
    do_ack("bp_ack");

    // Reset during WAIT of candidate 2
    set_tab(13'd100, 13'd50, 13'd20, 13'd10);
    do_start();
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_req && mem_idx == 2'd2) begin
        hit = 1'b1;
        break;
      end
    end
    chk("mid_reach", 32'(hit), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    i0 = n_init;
    do_start();
    wait_done("post_done");
    chk("post_sad", 32'(best_sad), 32'd10);
    chk("post_idx", 32'(best_idx), 32'd3);
    chk("post_inits", 32'(n_init - i0), 32'd4);
    do_ack("post_ack");

    // Every candidate at the maximum representable SAD
    set_tab(ALL1, ALL1, ALL1, ALL1);
    do_start();
    wait_done("max_done");
    chk("max_sad", 32'(best_sad), 32'(ALL1));
    chk("max_idx", 32'(best_idx), 32'd0);
    do_ack("max_ack");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
